// File: rtl/exec_stall_controller.sv
// exec_stall_controller: execute-stage sequencer. Detects load-use hazards
// (one-cycle stall plus EX bubble) and runs multi-cycle MUL/MLA operations by
// holding fetch/decode and the EX register for MULT_CYCLES cycles.
// Optional feature: define EXEC_STALL_COUNTER_EN to add a saturating counter
// of decode-stall cycles on stall_count_o; otherwise stall_count_o is tied to 0.

module exec_stall_controller #(
    parameter int ADDR_WIDTH  = 4,
    parameter int MULT_CYCLES = 3,
    parameter int CNT_WIDTH   = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  instr_valid_DECODE_i,
    input  logic [2:0]            reg_use_DECODE_i,
    input  logic [ADDR_WIDTH-1:0] reg_addr_1_DECODE_i,
    input  logic [ADDR_WIDTH-1:0] reg_addr_2_DECODE_i,
    input  logic [ADDR_WIDTH-1:0] reg_addr_3_DECODE_i,
    input  logic                  mem_read_EX_i,
    input  logic                  reg_write_en_EX_i,
    input  logic [ADDR_WIDTH-1:0] reg_dest_EX_i,
    input  logic                  multicycle_EX_i,
    input  logic                  flush_i,
    output logic                  stall_fetch_o,
    output logic                  stall_decode_o,
    output logic                  bubble_EX_o,
    output logic                  hold_EX_o,
    output logic                  mult_busy_o,
    output logic                  mult_last_o,
    output logic [CNT_WIDTH-1:0]  stall_count_o
);

    typedef enum logic {
        IDLE = 1'b0,
        MULT = 1'b1
    } state_t;

    // A one-cycle multi-cycle op needs no sequencing, so the request is ignored.
    localparam bit         MULT_ON   = (MULT_CYCLES > 1);
    // The first EX cycle is spent in IDLE and the last one at count 0.
    localparam logic [3:0] STEP_LOAD = MULT_ON ? 4'(MULT_CYCLES - 2) : 4'd0;

    state_t     state;
    logic [3:0] step;
    logic       src_match;
    logic       hazard;
    logic       mult_start;

    // Load-use detection against the EX destination, and multi-cycle request.
    always_comb begin
        src_match  = (reg_use_DECODE_i[0] && (reg_addr_1_DECODE_i == reg_dest_EX_i)) ||
                     (reg_use_DECODE_i[1] && (reg_addr_2_DECODE_i == reg_dest_EX_i)) ||
                     (reg_use_DECODE_i[2] && (reg_addr_3_DECODE_i == reg_dest_EX_i));
        hazard     = instr_valid_DECODE_i && mem_read_EX_i && reg_write_en_EX_i && src_match;
        mult_start = MULT_ON && multicycle_EX_i;
    end

    // Mealy output decode; reset and flush force every control low.
    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        stall_fetch_o  = 1'b0;
        stall_decode_o = 1'b0;
        bubble_EX_o    = 1'b0;
        hold_EX_o      = 1'b0;
        mult_busy_o    = 1'b0;
        mult_last_o    = 1'b0;
        if (!rst_i && !flush_i) begin
            unique case (state)
                IDLE: begin
                    // Multi-cycle wins over a (theoretically impossible) coincident hazard.
                    if (mult_start) begin
                        stall_fetch_o  = 1'b1;
                        stall_decode_o = 1'b1;
                        hold_EX_o      = 1'b1;
                        mult_busy_o    = 1'b1;
                    end else if (hazard) begin
                        stall_fetch_o  = 1'b1;
                        stall_decode_o = 1'b1;
                        bubble_EX_o    = 1'b1;
                    end
                end
                MULT: begin
                    stall_fetch_o  = 1'b1;
                    stall_decode_o = 1'b1;
                    mult_busy_o    = 1'b1;
                    if (step != 4'd0) hold_EX_o   = 1'b1;
                    else              mult_last_o = 1'b1;
                end
                default: ;
            endcase
        end
    end

    // State and step counter; flush aborts any op in flight.
    always_ff @(posedge clk_i or posedge rst_i) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples pre-edge values regardless of block evaluation order.
        if (rst_i) begin
            state <= IDLE;
            step  <= 4'd0;
        end else if (flush_i) begin
            state <= IDLE;
            step  <= 4'd0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (mult_start) begin
                        state <= MULT;
                        step  <= STEP_LOAD;
                    end
                end
                MULT: begin
                    if (step != 4'd0) step  <= step - 4'd1;
                    else              state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef EXEC_STALL_COUNTER_EN
    logic [CNT_WIDTH-1:0] stall_cnt;

    // Saturating count of decode-stall cycles; only reset clears it.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stall_cnt <= '0;
        end else if (stall_decode_o && (stall_cnt != {CNT_WIDTH{1'b1}})) begin
            stall_cnt <= stall_cnt + CNT_WIDTH'(1);
        end
    end

    assign stall_count_o = stall_cnt;
`else
    assign stall_count_o = '0;
`endif

endmodule

// File: doc/exec_stall_controller.md
Name: exec_stall_controller

Overview:
- Sequences the execute stage: detects load-use hazards and runs multi-cycle operations (MUL/MLA) by stalling fetch/decode and holding the EX pipeline register.
- Sits beside the execute datapath. Consumes decode-stage register addresses and EX-stage instruction info.
- Drives the stall, bubble and hold controls of the pipeline registers, plus ALU multi-cycle sequencing strobes.

Parameters:
- ADDR_WIDTH, 4, register address width.
- MULT_CYCLES, 3, total EX-stage cycles a multi-cycle op occupies (legal range 1..15).
- CNT_WIDTH, 32, width of the stall performance counter.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  reset, asynchronous, active-high.
- instr_valid_DECODE_i  in  1  decode stage holds a real instruction.
- reg_use_DECODE_i  in  3  bit k=1: decode reads reg_addr_(k+1).
- reg_addr_1_DECODE_i  in  ADDR_WIDTH  decode source register 1.
- reg_addr_2_DECODE_i  in  ADDR_WIDTH  decode source register 2.
- reg_addr_3_DECODE_i  in  ADDR_WIDTH  decode source register 3.
- mem_read_EX_i  in  1  instruction in EX is a load.
- reg_write_en_EX_i  in  1  instruction in EX writes a register.
- reg_dest_EX_i  in  ADDR_WIDTH  EX destination register.
- multicycle_EX_i  in  1  instruction in EX is multi-cycle.
- flush_i  in  1  pipeline redirect; kills decode/EX contents.
- stall_fetch_o  out  1  hold PC and fetch register.
- stall_decode_o  out  1  hold decode register.
- bubble_EX_o  out  1  load NOP into EX register.
- hold_EX_o  out  1  keep EX register contents.
- mult_busy_o  out  1  multi-cycle op in progress; ALU holds operands.
- mult_last_o  out  1  final multi-cycle cycle; ALU result valid.
- stall_count_o  out  CNT_WIDTH  stall cycle count (see Optional Feature).

Behaviour:
- Reset: state IDLE, counter 0, step count 0. While rst_i=1, all outputs are forced to 0 regardless of inputs.
- States: IDLE and MULT.
- Load-use hazard, combinational:
  - hz = instr_valid_DECODE_i & mem_read_EX_i & reg_write_en_EX_i & (any k with reg_use[k] & reg_addr_(k+1) == reg_dest_EX_i).
  - Evaluated only in IDLE, with multicycle_EX_i=0 and flush_i=0.
- IDLE, hz=1: assert stall_fetch_o, stall_decode_o, bubble_EX_o for that cycle (Mealy). Next state stays IDLE.
  - The next cycle the bubble is in EX, so the hazard clears and forwarding from MEM supplies the data.
  - Exactly one stall cycle per load-use.
- IDLE, multicycle_EX_i=1, flush_i=0, MULT_CYCLES>1:
  - Assert stall_fetch_o, stall_decode_o, hold_EX_o, mult_busy_o.
  - Load step counter with MULT_CYCLES-2; next state MULT.
- MULT:
  - Assert stall_fetch_o, stall_decode_o, mult_busy_o.
  - While counter>0: assert hold_EX_o and decrement.
  - When counter==0: assert mult_last_o, deassert hold_EX_o, next state IDLE; the EX register advances at that edge.
- Multi-cycle op occupies EX exactly MULT_CYCLES cycles, with stall outputs high for all of them.
- MULT_CYCLES=1: multicycle_EX_i is ignored, and no state change occurs.
- Back-to-back multi-cycle ops: the new op enters EX after mult_last_o, and IDLE sees it next cycle, so there are no dead cycles.
- flush_i=1 has top priority in any state:
  - All outputs 0 that cycle.
  - Next state IDLE, step counter cleared.
  - An aborted op produces no mult_last_o.
- hz and multicycle_EX_i both 1 cannot occur (EX holds one instruction). If seen, multicycle wins and bubble_EX_o stays 0.
- hold_EX_o and bubble_EX_o are never asserted together.

Optional Feature:
- Macro EXEC_STALL_COUNTER_EN.
- Defined: stall_count_o increments by 1 each cycle that stall_decode_o=1 and saturates at all-ones. It is cleared only by rst_i.
- Undefined: no counter register; stall_count_o is tied to 0.

Test Plan:
- Load-use: mem_read_EX_i=1, reg_write_en_EX_i=1, reg_dest_EX_i=5, decode reads r5 via reg_use=3'b001 -> stall_fetch/stall_decode/bubble_EX=1 for exactly 1 cycle; with dest=6 -> no stall.
- Multi-cycle, MULT_CYCLES=3: multicycle_EX_i=1 at cycle 0 ->
  - mult_busy_o=1 cycles 0-2; hold_EX_o=1 cycles 0-1; mult_last_o=1 cycle 2.
  - Stalls drop in cycle 3.
- Back-to-back multi-cycle: two MULs -> mult_last_o pulses at cycles 2 and 5, stalls continuous for cycles 0-5.
- Flush abort: flush_i=1 in cycle 1 of a MULT -> outputs 0 that cycle; state IDLE; no mult_last_o pulse.
- Reset mid-MULT: rst_i asserted asynchronously in cycle 1 -> outputs 0 immediately. After release, a hazard-free decode yields no stalls.
- Counter (EXEC_STALL_COUNTER_EN): one load-use plus one 3-cycle MUL -> stall_count_o=4. Force 2^CNT_WIDTH-1 via a small CNT_WIDTH=2 build -> holds at 3.
